// File: rtl/bcd_display_scanner.sv
// Two-digit seven-segment scanner for the safe's BCD display. Captures a 5-bit
// BCD word, multiplexes tens/units with dead time, blanking, blink and invalid-code dash.
module bcd_display_scanner #(
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_FRAMES   = 100,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       Clock,
    input  logic       nReset,
    input  logic       Load,
    input  logic [4:0] BCD,
    input  logic       Blink,
    output logic [6:0] Seg,
    output logic [1:0] Digit,
    output logic       Ack,
    output logic       Invalid
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);
    localparam logic [FW-1:0] FRAME_LAST  = FW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_OFF     = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {
        SLOT_UNITS = 1'b0,
        SLOT_TENS  = 1'b1
    } slot_t;

    slot_t          slot, slot_nxt;
    logic [PW-1:0]  presc;
    logic [FW-1:0]  frame_cnt;
    logic           blink_on;
    logic [4:0]     held;
    logic [4:0]     disp;
    logic           wrap;
    logic           frame_wrap;
    logic           disp_ok;
    logic [6:0]     seg_act;
    logic [6:0]     seg_nxt;
    logic [1:0]     digit_nxt;

    function automatic logic is_legal(input logic [4:0] code);
        return code[4] ? (code[3:0] <= 4'd5) : (code[3:0] <= 4'd9);
    endfunction

    // Active-high gfedcba patterns; polarity applied once at the output.
    function automatic logic [6:0] pattern(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign wrap       = (presc == PRESC_LAST);
    assign frame_wrap = wrap && (slot == SLOT_TENS);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            slot      <= SLOT_UNITS;
            presc     <= '0;
            frame_cnt <= '0;
            blink_on  <= 1'b1;
            held      <= '0;
            disp      <= '0;
            Ack       <= 1'b0;
            Invalid   <= 1'b0;
            Seg       <= SEG_OFF;
            Digit     <= '0;
        end else begin
            slot  <= slot_nxt;
            presc <= wrap ? '0 : presc + PW'(1);
            Ack   <= Load;
            if (Load) begin
                held    <= BCD;
                Invalid <= !is_legal(BCD);
            end
            // A load landing on the slot boundary bypasses the held register.
            if (wrap)
                disp <= Load ? BCD : held;
            if (!Blink) begin
                blink_on  <= 1'b1;
                frame_cnt <= '0;
            end else if (frame_wrap) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    blink_on  <= !blink_on;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
            Seg   <= seg_nxt;
            Digit <= digit_nxt;
        end
    end

    always_comb begin
        slot_nxt  = slot;
        seg_act   = '0;
        digit_nxt = '0;
        disp_ok   = is_legal(disp);
        if (wrap)
            slot_nxt = (slot == SLOT_UNITS) ? SLOT_TENS : SLOT_UNITS;
        if ((presc >= PRESC_BLANK) && blink_on) begin
            if (!disp_ok) begin
                seg_act   = 7'h40;
                digit_nxt = (slot == SLOT_TENS) ? 2'b10 : 2'b01;
            end else if (slot == SLOT_TENS) begin
                if (disp[4]) begin
                    seg_act   = pattern(4'd1);
                    digit_nxt = 2'b10;
                end
            end else begin
                seg_act   = pattern(disp[3:0]);
                digit_nxt = 2'b01;
            end
        end
        seg_nxt = SEG_ACTIVE_LOW ? ~seg_act : seg_act;
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed scoreboard bench for bcd_display_scanner with a small scan-position model
// (SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, active-low segments).
module tb_bcd_display_scanner;

    logic       Clock = 1'b0;
    logic       nReset;
    logic       Load;
    logic [4:0] BCD;
    logic       Blink;
    logic [6:0] Seg;
    logic [1:0] Digit;
    logic       Ack;
    logic       Invalid;

    bcd_display_scanner #(
        .SCAN_DIV(8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .Clock(Clock),
        .nReset(nReset),
        .Load(Load),
        .BCD(BCD),
        .Blink(Blink),
        .Seg(Seg),
        .Digit(Digit),
        .Ack(Ack),
        .Invalid(Invalid)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        bit         pins;
        logic [6:0] seg;
        logic [1:0] dig;
        logic       ack;
        logic       inv;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   t     = 0;
    logic inv_m = 1'b0;
    logic [6:0] pat_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Expected {Seg, Digit} shown after edge e (edges counted from reset release).
    function automatic logic [8:0] exp_pins(logic [4:0] v, int e, bit on);
        int p     = (e - 1) % 8;
        int s     = ((e - 1) / 8) % 2;
        int units = int'(v[3:0]);
        int tens  = int'(v[4]);
        bit legal = (units <= 9) && (tens * 10 + units <= 15);
        logic [6:0] hi = 7'h00;
        logic [1:0] d  = 2'b00;
        if (p >= 2 && on) begin
            if (!legal) begin
                hi = 7'h40;
                d  = (s == 1) ? 2'b10 : 2'b01;
            end else if (s == 1) begin
                if (tens == 1) begin
                    hi = pat_hi[1];
                    d  = 2'b10;
                end
            end else begin
                hi = pat_hi[units];
                d  = 2'b01;
            end
        end
        return {~hi, d};
    endfunction

    task automatic chk(string tag, logic [6:0] obs, logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0d obs=%h exp=%h", tag, t, obs, exp);
        end
    endtask

    task automatic push(bit pins, logic [8:0] sd, logic ack);
        exp_t x;
        x.pins = pins;
        x.seg  = sd[8:2];
        x.dig  = sd[1:0];
        x.ack  = ack;
        x.inv  = inv_m;
        q.push_back(x);
    endtask

    task automatic compare_head();
        exp_t x;
        total++;
        assert (q.size() > 0) else begin
            bad++;
            $error("FAIL scoreboard_empty t=%0d obs=%0d exp=%0d", t, 0, 1);
        end
        if (q.size() > 0) begin
            x = q.pop_front();
            chk("ack", {6'd0, Ack}, {6'd0, x.ack});
            chk("invalid", {6'd0, Invalid}, {6'd0, x.inv});
            if (x.pins) begin
                chk("seg", Seg, x.seg);
                chk("digit", {5'd0, Digit}, {5'd0, x.dig});
            end
        end
    endtask

    task automatic step();
        @(posedge Clock);
        t++;
        #1;
        compare_head();
    endtask

    task automatic idle_to(int m, int r);
        while (t % m != r) begin
            push(1'b0, 9'd0, 1'b0);
            step();
        end
    endtask

    task automatic do_load(logic [4:0] v);
        Load  = 1'b1;
        BCD   = v;
        inv_m = !((int'(v[3:0]) <= 9) && (int'(v[4]) * 10 + int'(v[3:0]) <= 15));
        push(1'b0, 9'd0, 1'b1);
        step();
        Load = 1'b0;
    endtask

    // Checks n edges of scan output showing v; edges off_lo..off_hi are in blink-off.
    task automatic window(int n, logic [4:0] v, int off_lo, int off_hi);
        int t0 = t;
        for (int k = 1; k <= n; k++)
            push(1'b1, exp_pins(v, t0 + k, !(k >= off_lo && k <= off_hi)), 1'b0);
        for (int k = 1; k <= n; k++)
            step();
    endtask

    initial begin
        nReset = 1'b0;
        Load   = 1'b0;
        BCD    = '0;
        Blink  = 1'b0;
        repeat (2) @(posedge Clock);
        #3 nReset = 1'b1;
        t = 0;

        // Scan from reset shows "0", then reset asserted between edges.
        window(4, 5'h00, 0, -1);
        Load  = 1'b1;
        BCD   = 5'b1_1010;
        inv_m = 1'b1;
        push(1'b1, exp_pins(5'h00, t + 1, 1'b1), 1'b1);
        step();
        Load = 1'b0;
        #2 nReset = 1'b0;
        #1;
        inv_m = 1'b0;
        push(1'b1, {7'h7F, 2'b00}, 1'b0);
        compare_head();
        @(posedge Clock);
        #3 nReset = 1'b1;
        t = 0;
        window(16, 5'h00, 0, -1);

        // Value 15
        do_load(5'b1_0101);
        idle_to(16, 0);
        window(16, 5'b1_0101, 0, -1);

        // Leading-zero blanking
        do_load(5'b0_0111);
        idle_to(16, 0);
        window(16, 5'b0_0111, 0, -1);

        // Invalid code, then back to a legal one
        do_load(5'b1_1010);
        idle_to(16, 0);
        window(16, 5'b1_1010, 0, -1);
        do_load(5'b0_0011);
        idle_to(16, 0);
        window(16, 5'b0_0011, 0, -1);

        // Blink: 32 on, 32 off, 32 on; then drop Blink inside the next off phase
        do_load(5'b1_0101);
        idle_to(16, 0);
        Blink = 1'b1;
        window(96, 5'b1_0101, 33, 64);
        window(8, 5'b1_0101, 1, 8);
        Blink = 1'b0;
        window(24, 5'b1_0101, 1, 1);

        // Load coinciding with the slot boundary
        idle_to(16, 15);
        do_load(5'b0_1000);
        window(16, 5'b0_1000, 0, -1);

        // Back-to-back loads: one Ack each, last value wins
        do_load(5'b1_0010);
        do_load(5'b0_0100);
        idle_to(16, 0);
        window(16, 5'b0_0100, 0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0d obs=%0d exp=%0d", t, 0, 1);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
- Downstream consumer of the 4-bit binary-to-BCD converter in the digital safe datapath.
- Captures the 5-bit BCD word (tens bit plus units nibble) on a load strobe.
- Time-multiplexes the tens and units digits onto one shared seven-segment bus with per-digit enables.
- Provides leading-zero blanking, anti-ghosting dead time, a blink mode for lockout/alarm indication, and invalid-code detection.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot; two slots form one frame.
- BLANK_CYCLES, 500: dead-time cycles at the start of each slot, during which all digits are off. Must be < SCAN_DIV.
- BLINK_FRAMES, 100: frames per blink half-period.
- SEG_ACTIVE_LOW, 1: 1 means segment outputs are driven low to light.

Ports:
- Clock, input, 1: system clock, rising edge.
- nReset, input, 1: asynchronous, active-low reset.
- Load, input, 1: capture strobe for BCD.
- BCD, input, 5: BCD[4] is the tens digit (0/1); BCD[3:0] is the units digit.
- Blink, input, 1: level; 1 enables blinking of the whole display.
- Seg, output, 7: segments gfedcba, with Seg[0] = a. Polarity is set by SEG_ACTIVE_LOW.
- Digit, output, 2: one-hot active-high enables. Digit[0] = units, Digit[1] = tens.
- Ack, output, 1: one-cycle pulse confirming a capture.
- Invalid, output, 1: high while the held code is not a legal converter output.

Behaviour:
- **Reset (async, nReset=0):**
  - Seg = all segments off (7'h7F when active-low).
  - Digit = 2'b00, Ack = 0, Invalid = 0.
  - Held value = 0, displayed value = 0, prescaler = 0, slot = units, blink phase = on, frame counter = 0.
  - Reset asserted mid-scan forces these values immediately.
  - After release, scanning starts at prescaler 0 in the units slot.
- **Capture:**
  - On each rising edge with Load=1, BCD goes into the held register and Ack = 1 for exactly the next cycle.
  - Back-to-back Loads produce one Ack per Load; the last captured value wins.
- **Validity:**
  - Legal codes are units ≤ 9 with tens = 0, or units ≤ 5 with tens = 1 (values 0..15).
  - Invalid is registered in the same edge as the capture.
- **Display update:**
  - The displayed register copies the held register when the prescaler wraps to 0 (slot boundary), so a digit never changes mid-slot.
  - If Load and a slot boundary coincide, the displayed register takes BCD directly; the new value shows in that slot.
- **Scan:**
  - The prescaler counts 0..SCAN_DIV-1 and wraps. The slot toggles units→tens→units at each wrap.
  - Prescaler < BLANK_CYCLES: Digit = 00, Seg off.
  - Otherwise, the current slot's Digit bit = 1 and Seg = that digit's pattern.
  - Seg and Digit are registered: one-cycle latency from prescaler/slot state to pins.
- **Leading zero:** in the tens slot with displayed tens = 0 (and valid), Digit = 00 and Seg is off. The units digit is always shown, so value 0 displays "0".
- **Invalid display:** both slots show dash (segment g only); leading-zero blanking is not applied.
- **Blink:**
  - With Blink = 1, the frame counter increments at each tens→units wrap. The phase toggles every BLINK_FRAMES frames.
  - In the off phase, Digit = 00 and Seg is off for both slots.
  - With Blink = 0, the phase is forced on and the frame counter is held at 0, so a new Blink assertion always starts in the on phase.
- **Patterns (active-high, gfedcba):**
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F, dash = 40, off = 00.
  - Invert all patterns when SEG_ACTIVE_LOW = 1.

Test Plan:
All scenarios use SCAN_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2, SEG_ACTIVE_LOW=1.

1. **Async reset:** pull nReset low mid-slot, between clock edges → Seg = 7F, Digit = 00, Ack = 0 without waiting for a clock edge. Release → first units slot starts at prescaler 0.
2. **Value 15:** Load 5'b1_0101 → Ack high exactly one cycle. From the next slot boundary:
   - units slot: 2 cycles of Digit = 00, then 6 cycles of Digit = 01 with Seg = 12;
   - tens slot: Digit = 10 with Seg = 79.
3. **Leading zero:** Load 5'b0_0111 → tens slot Digit = 00 and Seg = 7F for the whole slot; units slot Seg = 78, Digit = 01.
4. **Invalid code:** Load 5'b1_1010 → Invalid = 1 after the capture edge; both slots Seg = 3F with their Digit bits asserted. Load 5'b0_0011 → Invalid = 0, units Seg = 30.
5. **Blink:** value 15 with Blink = 1 → 32 cycles displayed, then 32 cycles of Digit = 00, repeating. Deassert Blink during the off phase → digits reappear at the next active window.
6. **Load on boundary:** Load 5'b0_1000 in the same cycle the prescaler wraps → that slot already shows Seg = 00, Digit = 01 after the dead time. Two consecutive Loads → two Ack pulses, and the last value is displayed.
